ms_alarm: RTL and testbench
===========================

MS_ALARM -- requirements
Module: ms_alarm

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port stb, input, 1: bus strobe, one cycle per access.
REQ-004 SHALL have port we, input, 1: write (1) or read (0) qualifier for stb.
REQ-005 SHALL have port addr, input, 2: register select (0 PERIOD, 1 CTRL, 2 COUNT, 3 STATUS).
REQ-006 SHALL have port data_in, input, 32: write data.
REQ-007 SHALL have port ms_tick, input, 1: one-cycle millisecond pulse from the ms timer.
REQ-008 SHALL have port data_out, output, 32: read data, zero when not reading.
REQ-009 SHALL have port ack, output, 1: bus acknowledge.
REQ-010 SHALL have port irq, output, 1: alarm interrupt, level.

Function
REQ-011 SHALL drive ack = stb combinationally, giving zero wait states for reads and writes.
REQ-012 SHALL drive data_out from the addressed register when stb & ~we, else 32'h0.
REQ-013 SHALL store PERIOD as 32 bits, read/write; a write while running SHALL NOT change COUNT and takes effect at the next reload.
REQ-014 SHALL implement CTRL with bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit2 IE; bits 31:3 read as 0, writes to them ignored.
REQ-015 SHALL treat COUNT as read-only, 32 bits, holding the remaining milliseconds; writes ignored.
REQ-016 SHALL implement STATUS with bit0 EXP (sticky expiry) and bit1 OVR (expiry while EXP already set); writing 1 to a bit clears it, writing 0 leaves it unchanged.
REQ-017 SHALL have two states: IDLE (EN=0) and RUN (EN=1).
REQ-018 On a CTRL write with EN 0->1: SHALL load COUNT <= PERIOD and enter RUN.
REQ-019 On a CTRL write with EN 1->1: SHALL update MODE and IE only; COUNT SHALL NOT be touched.
REQ-020 On a CTRL write with EN 1->0: SHALL enter IDLE, freezing COUNT at its current value.
REQ-021 In RUN, on ms_tick with COUNT > 1: SHALL decrement COUNT by 1.
REQ-022 In RUN, on ms_tick with COUNT == 1: SHALL signal expiry in that cycle, then set EXP the next cycle.
REQ-023 On expiry, if EXP was already 1: SHALL set OVR.
REQ-024 On expiry in periodic mode: SHALL reload COUNT <= PERIOD, using the PERIOD value current in that cycle.
REQ-025 On expiry in one-shot mode: SHALL set COUNT <= 0, clear EN and enter IDLE.
REQ-026 With COUNT == 0 in RUN (PERIOD was 0): SHALL never expire and SHALL ignore ms_tick; a PERIOD of 0 never alarms.
REQ-027 In IDLE: SHALL ignore ms_tick.
REQ-028 On a ms_tick coinciding with a CTRL write of EN 0->1: SHALL apply the load only; the first decrement comes on the next ms_tick.
REQ-029 On a STATUS clear write coinciding with expiry: expiry SHALL win; the affected bits end set.
REQ-030 On a CTRL write of EN 1->0 coinciding with expiry: the write SHALL win; no expiry, EXP unchanged.
REQ-031 SHALL drive irq = EXP & IE, registered-state derived, with no combinational path from bus inputs.
REQ-032 SHALL use no arithmetic wider than 32 bits and SHALL NOT let COUNT underflow below 0.

Reset
REQ-033 On rst asserted, asynchronously: PERIOD=0, CTRL=0, COUNT=0, STATUS=0, state IDLE, irq=0.
REQ-034 On rst asserted: data_out SHALL follow REQ-012, and ack SHALL follow stb.
REQ-035 On rst asserted mid-count: SHALL abort the count with no expiry; operation resumes only after a new EN 0->1 write.

Verification
REQ-036 Bench SHALL run one-shot: PERIOD=3, CTRL=0b101, three ms_ticks -> EXP=1 and irq=1 after the third tick; COUNT=0, EN=0; a fourth tick causes no change.
REQ-037 Bench SHALL run periodic with overrun: PERIOD=2, CTRL=0b111, four ticks without clearing -> EXP=1, OVR=1, COUNT=2; write STATUS=3 -> STATUS=0, irq=0.
REQ-038 Bench SHALL check simultaneous events: STATUS clear write in the expiry cycle -> EXP stays 1; a disable write in the expiry cycle -> EXP stays 0, COUNT frozen at 1.
REQ-039 Bench SHALL check PERIOD=0 with EN=1: 10 ticks -> COUNT=0, EXP=0. It SHALL also check a PERIOD write of 5 while running with COUNT=4: COUNT continues 3, 2, 1, then reloads 5.
REQ-040 Bench SHALL check bus and reset: every stb gives ack in the same cycle; a read of COUNT mid-run returns the exact value; rst asserted between ticks -> all registers 0 immediately, irq=0.

Source files
------------

// File: rtl/ms_alarm_if.sv
// Bus interface for the millisecond alarm: single-cycle strobe/ack register access.
// Ports: stb, we, addr[1:0], data_in[31:0] from master; data_out[31:0], ack from slave.
// master = bus initiator, slave = ms_alarm register block.
interface ms_alarm_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, output we, output addr, output data_in,
                  input data_out, input ack);
  modport slave  (input stb, input we, input addr, input data_in,
                  output data_out, output ack);
endinterface

// File: rtl/ms_alarm.sv
// Millisecond alarm timer: counts ms_tick pulses down from PERIOD, flags expiry
// in sticky STATUS (EXP/OVR), one-shot or periodic, level irq = EXP & IE.
// Ports: clk, rst (async high), bus (ms_alarm_if.slave), ms_tick, irq.
module ms_alarm (
  input  logic        clk,
  input  logic        rst,
  ms_alarm_if.slave   bus,
  input  logic        ms_tick,
  output logic        irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [31:0] period;
  logic [31:0] count;
  logic        mode;
  logic        ie;
  logic        exp;
  logic        ovr;

  logic        wr;
  logic        wr_period;
  logic        wr_ctrl;
  logic        wr_status;
  logic        disable_wr;
  logic        tick_run;
  logic        expiry;
  logic [31:0] rd_val;

  assign wr        = bus.stb & bus.we;
  assign wr_period = wr & (bus.addr == 2'd0);
  assign wr_ctrl   = wr & (bus.addr == 2'd1);
  assign wr_status = wr & (bus.addr == 2'd3);

  // A disable write in the same cycle as a tick suppresses the tick entirely,
  // so a coincident expiry never happens and EXP is left alone.
  assign disable_wr = wr_ctrl & ~bus.data_in[0];
  assign tick_run   = (state == RUN) & ms_tick & ~disable_wr;
  // COUNT == 0 in RUN (PERIOD was 0) never matches here, so it never expires.
  assign expiry     = tick_run & (count == 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      period <= 32'd0;
      count  <= 32'd0;
      mode   <= 1'b0;
      ie     <= 1'b0;
      exp    <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (wr_period) period <= bus.data_in;

      // Write-1-to-clear, but a same-cycle expiry sets the bit back.
      // OVR looks at EXP as it was before any clear in this cycle.
      exp <= (exp & ~(wr_status & bus.data_in[0])) | expiry;
      ovr <= (ovr & ~(wr_status & bus.data_in[1])) | (expiry & exp);

      case (state)
        IDLE: begin
          // Ticks are ignored; an enabling write loads COUNT only, so a tick
          // in the same cycle does not also decrement.
          if (wr_ctrl) begin
            mode <= bus.data_in[1];
            ie   <= bus.data_in[2];
            if (bus.data_in[0]) begin
              count <= period;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (wr_ctrl) begin
            mode <= bus.data_in[1];
            ie   <= bus.data_in[2];
            if (!bus.data_in[0]) state <= IDLE;  // COUNT frozen as-is
          end
          if (tick_run) begin
            if (count == 32'd1) begin
              // Mode in force before any same-cycle CTRL write decides reload.
              if (mode) begin
                count <= period;
              end else begin
                count <= 32'd0;
                state <= IDLE;
              end
            end else if (count > 32'd1) begin
              count <= count - 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (bus.addr)
      2'd0: rd_val = period;
      2'd1: rd_val = {29'd0, ie, mode, (state == RUN)};
      2'd2: rd_val = count;
      2'd3: rd_val = {30'd0, ovr, exp};
      default: rd_val = 32'd0;
    endcase
  end

  assign bus.ack      = bus.stb;
  assign bus.data_out = (bus.stb & ~bus.we) ? rd_val : 32'd0;

  // Purely register-derived: no path from bus inputs.
  assign irq = exp & ie;

endmodule

// File: tb/tb_ms_alarm.sv
module tb_ms_alarm;

  logic clk;
  logic rst;
  logic ms_tick;
  logic irq;

  ms_alarm_if bus ();

  ms_alarm dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ms_tick (ms_tick),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] last_rd;

  // Reference model: architectural register contents.
  logic [31:0] m_period, m_count;
  logic        m_en, m_mode, m_ie, m_exp, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_period = 0; m_count = 0; m_en = 0; m_mode = 0; m_ie = 0; m_exp = 0; m_ovr = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return m_period;
      2'd1: return {29'd0, m_ie, m_mode, m_en};
      2'd2: return m_count;
      default: return {30'd0, m_ovr, m_exp};
    endcase
  endfunction

  // One clock of the alarm's rules, applied to the architectural state.
  task automatic model_update(input logic s, input logic w, input logic [1:0] a,
                              input logic [31:0] d, input logic t);
    logic is_wr, ctrl_wr, turn_off, turn_on, counting, fire, was_exp, was_mode;
    is_wr    = s & w;
    ctrl_wr  = is_wr && a == 2'd1;
    turn_off = ctrl_wr && m_en && !d[0];
    turn_on  = ctrl_wr && !m_en && d[0];
    counting = m_en && t && !turn_off;
    fire     = counting && m_count == 1;
    was_exp  = m_exp;
    was_mode = m_mode;

    if (is_wr && a == 2'd3) begin
      if (d[0]) m_exp = 0;
      if (d[1]) m_ovr = 0;
    end
    if (ctrl_wr) begin
      m_en = d[0]; m_mode = d[1]; m_ie = d[2];
    end
    if (turn_on) m_count = m_period;
    else if (fire) begin
      m_exp = 1;
      if (was_exp) m_ovr = 1;
      if (was_mode) m_count = m_period;
      else begin m_count = 0; m_en = 0; end
    end else if (counting && m_count > 1) m_count = m_count - 1;
    if (is_wr && a == 2'd0) m_period = d;
  endtask

  // One bus cycle: drive, check combinational outputs, clock, check irq.
  task automatic step(input logic s, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic t);
    bus.stb = s; bus.we = w; bus.addr = a; bus.data_in = d; ms_tick = t;
    #1;
    check("ack", {31'd0, bus.ack}, {31'd0, s});
    check("data_out", bus.data_out, (s && !w) ? model_read(a) : 32'd0);
    last_rd = bus.data_out;
    @(posedge clk);
    model_update(s, w, a, d, t);
    #1;
    bus.stb = 0; bus.we = 0; ms_tick = 0;
    check("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1, 1, a, d, 0);
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 1);
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
    step(1, 0, a, 0, 0);
    check(tag, last_rd, v);
  endtask

  initial begin
    rst = 1; ms_tick = 0;
    bus.stb = 0; bus.we = 0; bus.addr = 0; bus.data_in = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;

    // Reset state
    expect_reg("rst_period", 0, 0);
    expect_reg("rst_ctrl",   1, 0);
    expect_reg("rst_count",  2, 0);
    expect_reg("rst_status", 3, 0);

    // One-shot
    wr(0, 3); wr(1, 5);
    expect_reg("os_count_load", 2, 3);
    tick(); tick();
    expect_reg("os_count_mid", 2, 1);
    tick();
    check("os_irq", {31'd0, irq}, 32'd1);
    expect_reg("os_status", 3, 1);
    expect_reg("os_count",  2, 0);
    expect_reg("os_ctrl",   1, 4);
    tick();
    expect_reg("os_count_after", 2, 0);
    expect_reg("os_status_after", 3, 1);
    wr(3, 3);

    // Periodic with overrun
    wr(0, 2); wr(1, 7);
    for (int i = 0; i < 4; i++) tick();
    expect_reg("per_status", 3, 3);
    expect_reg("per_count",  2, 2);
    wr(3, 3);
    expect_reg("per_clr", 3, 0);
    check("per_irq_clr", {31'd0, irq}, 32'd0);

    // Status clear coinciding with expiry: expiry wins
    tick();
    expect_reg("sim_count1", 2, 1);
    step(1, 1, 3, 3, 1);
    expect_reg("sim_clr_exp", 3, 1);
    expect_reg("sim_reload", 2, 2);
    wr(3, 3);
    tick();
    // Disable coinciding with expiry: write wins, COUNT frozen
    step(1, 1, 1, 0, 1);
    expect_reg("sim_dis_status", 3, 0);
    expect_reg("sim_dis_count",  2, 1);
    expect_reg("sim_dis_ctrl",   1, 0);

    // PERIOD = 0 never alarms
    wr(0, 0); wr(1, 1);
    for (int i = 0; i < 10; i++) tick();
    expect_reg("p0_count",  2, 0);
    expect_reg("p0_status", 3, 0);
    wr(1, 0);

    // PERIOD write while running takes effect at next reload
    wr(0, 4); wr(1, 3);
    wr(0, 5);
    expect_reg("pw_count4", 2, 4);
    tick(); expect_reg("pw_count3", 2, 3);
    tick(); expect_reg("pw_count2", 2, 2);
    tick(); expect_reg("pw_count1", 2, 1);
    tick(); expect_reg("pw_reload", 2, 5);
    expect_reg("pw_exp", 3, 1);

    // Asynchronous reset between ticks
    wr(1, 7);
    tick();
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2;
    rst = 1;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus.stb = 1; bus.we = 0;
    for (int a = 0; a < 4; a++) begin
      bus.addr = a[1:0];
      #1;
      check("rst_read", bus.data_out, 32'd0);
      check("rst_ack", {31'd0, bus.ack}, 32'd1);
    end
    bus.stb = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    expect_reg("post_rst_count",  2, 0);
    expect_reg("post_rst_status", 3, 0);
    expect_reg("post_rst_ctrl",   1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r, d;
      logic [1:0]  a;
      logic        w, s, t;
      r = $urandom;
      s = (r[3:0] < 4'd11);
      w = r[4] & r[5];
      a = r[7:6];
      t = (r[10:8] < 3'd3);
      d = $urandom;
      if (a == 2'd0) d = {29'd0, d[2:0]};
      if (a == 2'd1 && r[13:11] != 3'd0) d[0] = 1'b1;
      step(s, w, a, d, t);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
